pc_sequencer: RTL and testbench
===============================

Name: pc_sequencer

Overview:
- Control block for the program counter register.
- Decides each cycle whether the PC loads (WEN) and what value it loads (sequential +4, branch/jump redirect, or a deferred redirect).
- Coordinates with the instruction-memory handshake (ihit) and the hazard stall.
- Sits between the fetch stage, hazard unit and the PC register; also owns the halt state and a fetch counter.

Parameters:
PC_INIT, 32'h0, value pc_nxt/pend_pc assume on reset; must match the PC register's reset value
CNT_W, 16, width of the saturating valid-fetch counter

Ports:
CLK  input  1  clock, rising edge
nRST  input  1  asynchronous active-low reset
pco  input  32  current PC register output
ihit  input  1  instruction memory returned the word at pco this cycle
stall  input  1  hazard unit freezes fetch
redirect_en  input  1  resolved branch/jump/JR redirect from a later stage
redirect_pc  input  32  redirect target
halt  input  1  decode saw HALT in the instruction fetched this cycle
pc_wen  output  1  drives PC register WEN
pc_nxt  output  32  drives PC register pci
iREN  output  1  instruction memory read enable
fetch_valid  output  1  the word at pco is a valid, non-squashed fetch
halted  output  1  sequencer in HALTED state
fetch_cnt  output  CNT_W  count of valid fetches, saturating

Behaviour:
- Reset (nRST low, asynchronous): state RUN, pend_valid 0, pend_pc PC_INIT, fetch_cnt 0, halted 0. Any pending redirect is discarded.
- States:
  - RUN: iREN 1.
  - HALTED: iREN 0, pc_wen 0, fetch_valid 0.
  - HALTED is left only by reset.
- adv = ihit & ~stall & (state==RUN).
- pc_wen = adv. This is combinational; the PC updates at the next rising edge, i.e. 1-cycle latency from decision to pco.
- pc_nxt priority (combinational, evaluated every cycle):
  - redirect_en → redirect_pc
  - else pend_valid → pend_pc
  - else pco+4
  - Bits [1:0] are forced to 2'b00. pco+4 wraps modulo 2^32 (32'hFFFFFFFC → 32'h0).
- Deferred redirect:
  - redirect_en & ~adv: latch pend_pc ← redirect_pc, pend_valid ← 1.
  - A later redirect_en while pend_valid=1 overwrites pend_pc.
  - adv & ~redirect_en & pend_valid: consume it (pend_valid ← 0).
  - adv & redirect_en: pend_valid ← 0, since the live redirect supersedes any pending one.
- fetch_valid = ihit & (state==RUN) & ~redirect_en & ~pend_valid. A word fetched down the wrong path is squashed.
- Halt:
  - halt & fetch_valid & ~stall → state HALTED at the next edge.
  - The PC still loads pco+4 on that edge.
  - halt with redirect_en or pend_valid is ignored, because the HALT is on a squashed path.
  - halt with stall is held off until the stall clears.
- fetch_cnt increments on cycles with fetch_valid & ~stall; it saturates at all-ones and does not wrap.
- Simultaneous stall & redirect_en: the redirect is deferred, never lost.
- ihit low for N cycles: pc_wen stays 0 for those N cycles and iREN stays 1.

Test Plan:
- Reset with PC_INIT=0, then ihit=1, no stall for 4 cycles → pc_wen=1 each cycle, pc_nxt 4, 8, 12, 16; fetch_cnt=4; fetch_valid=1 throughout.
- pco=32'h40, redirect_en=1 with redirect_pc=32'h100, ihit=1 → pc_nxt=32'h100, pc_wen=1, fetch_valid=0. Next cycle pco=32'h100, fetch_valid=1.
- redirect_en=1 (target 32'h200) while ihit=0 for 3 cycles → pc_wen=0 and pend_valid=1 during those cycles. First ihit=1 cycle: pc_nxt=32'h200, pend_valid clears, fetch_valid=0 on that cycle.
- Stall & redirect (target 32'h300) in one cycle, then a second redirect (target 32'h400) while still stalled → on stall release, pc_nxt=32'h400.
- halt=1 with fetch_valid=1 at pco=32'h20 → pc_nxt=32'h24 loaded; halted=1, iREN=0 thereafter. A halt coincident with redirect_en leaves halted=0. Asserting nRST mid-HALTED gives halted=0, fetch_cnt=0.
- Boundary cases: pco=32'hFFFFFFFC advancing gives pc_nxt=0; redirect_pc=32'h103 gives pc_nxt=32'h100; with CNT_W=4, 20 valid fetches leave fetch_cnt=4'hF.

Source files
------------

// File: rtl/pc_sequencer.sv
// PC sequencer: decides PC register load/next value, tracks deferred redirects,
// owns the halt state and a saturating count of valid fetches.
module pc_sequencer #(
   parameter logic [31:0] PC_INIT = 32'h0,
   parameter int unsigned CNT_W   = 16
) (
   input  logic             CLK,
   input  logic             nRST,
   input  logic [31:0]      pco,
   input  logic             ihit,
   input  logic             stall,
   input  logic             redirect_en,
   input  logic [31:0]      redirect_pc,
   input  logic             halt,
   output logic             pc_wen,
   output logic [31:0]      pc_nxt,
   output logic             iREN,
   output logic             fetch_valid,
   output logic             halted,
   output logic [CNT_W-1:0] fetch_cnt
);

   typedef enum logic {RUN, HALTED} state_t;

   state_t            state, state_n;
   logic              pend_valid, pend_valid_n;
   logic [31:0]       pend_pc, pend_pc_n;
   logic [CNT_W-1:0]  fetch_cnt_n;
   logic              run;
   logic              adv;

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state      <= RUN;
         pend_valid <= 1'b0;
         pend_pc    <= PC_INIT;
         fetch_cnt  <= '0;
      end else begin
         state      <= state_n;
         pend_valid <= pend_valid_n;
         pend_pc    <= pend_pc_n;
         fetch_cnt  <= fetch_cnt_n;
      end
   end

   always_comb begin
      state_n      = state;
      pend_valid_n = pend_valid;
      pend_pc_n    = pend_pc;
      fetch_cnt_n  = fetch_cnt;

      run         = (state == RUN);
      adv         = ihit & ~stall & run;
      iREN        = run;
      pc_wen      = adv;
      fetch_valid = ihit & run & ~redirect_en & ~pend_valid;

      if (redirect_en)
         pc_nxt = redirect_pc;
      else if (pend_valid)
         pc_nxt = pend_pc;
      else
         pc_nxt = pco + 32'd4;
      pc_nxt[1:0] = 2'b00;

      // Any PC load retires the pending target; a live redirect that cannot load yet is parked.
      if (adv) begin
         pend_valid_n = 1'b0;
      end else if (redirect_en) begin
         pend_valid_n = 1'b1;
         pend_pc_n    = redirect_pc;
      end

      if (halt & fetch_valid & ~stall)
         state_n = HALTED;

      if (fetch_valid & ~stall & (fetch_cnt != '1))
         fetch_cnt_n = fetch_cnt + 1'b1;
   end

   assign halted = (state == HALTED);

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed self-checking bench for pc_sequencer; the bench plays the PC register.
module tb_pc_sequencer;

   logic        CLK = 1'b0;
   logic        nRST;
   logic [31:0] pco;
   logic        ihit, stall, redirect_en, halt;
   logic [31:0] redirect_pc;
   logic        pc_wen, iREN, fetch_valid, halted;
   logic [31:0] pc_nxt;
   logic [3:0]  fetch_cnt;

   int unsigned n_tests = 0;
   int unsigned n_fail  = 0;

   pc_sequencer #(.PC_INIT(32'h0), .CNT_W(4)) dut (
      .CLK(CLK), .nRST(nRST), .pco(pco), .ihit(ihit), .stall(stall),
      .redirect_en(redirect_en), .redirect_pc(redirect_pc), .halt(halt),
      .pc_wen(pc_wen), .pc_nxt(pc_nxt), .iREN(iREN), .fetch_valid(fetch_valid),
      .halted(halted), .fetch_cnt(fetch_cnt)
   );

   always #5 CLK = ~CLK;

   // One clock; the PC register loads pc_nxt when pc_wen was high before the edge.
   task automatic step();
      logic        w;
      logic [31:0] n;
      w = pc_wen;
      n = pc_nxt;
      @(posedge CLK);
      #1;
      if (w) pco = n;
   endtask

   task automatic do_reset();
      nRST = 1'b0; ihit = 1'b0; stall = 1'b0; redirect_en = 1'b0;
      redirect_pc = '0; halt = 1'b0; pco = '0;
      @(negedge CLK);
      nRST = 1'b1;
      @(posedge CLK);
      #1;
   endtask

   task automatic test_reset();
      nRST = 1'b0; ihit = 1'b0; stall = 1'b0; redirect_en = 1'b0;
      redirect_pc = '0; halt = 1'b0; pco = '0;
      #1;
      n_tests++; if (halted !== 1'b0) begin n_fail++; $display("FAIL rst_halted: got %b expected 0", halted); end
      n_tests++; if (fetch_cnt !== 4'h0) begin n_fail++; $display("FAIL rst_cnt: got %h expected 0", fetch_cnt); end
      n_tests++; if (iREN !== 1'b1) begin n_fail++; $display("FAIL rst_iren: got %b expected 1", iREN); end
      n_tests++; if (pc_wen !== 1'b0) begin n_fail++; $display("FAIL rst_wen: got %b expected 0", pc_wen); end
      n_tests++; if (pc_nxt !== 32'h4) begin n_fail++; $display("FAIL rst_nxt: got %h expected 00000004", pc_nxt); end
      @(negedge CLK);
      nRST = 1'b1;
      @(posedge CLK);
      #1;
   endtask

   task automatic test_sequential();
      logic [31:0] exp;
      ihit = 1'b1;
      for (int i = 0; i < 4; i++) begin
         exp = 32'(4 * (i + 1));
         #1;
         n_tests++; if (pc_wen !== 1'b1) begin n_fail++; $display("FAIL seq_wen[%0d]: got %b expected 1", i, pc_wen); end
         n_tests++; if (pc_nxt !== exp) begin n_fail++; $display("FAIL seq_nxt[%0d]: got %h expected %h", i, pc_nxt, exp); end
         n_tests++; if (fetch_valid !== 1'b1) begin n_fail++; $display("FAIL seq_fv[%0d]: got %b expected 1", i, fetch_valid); end
         step();
      end
      n_tests++; if (fetch_cnt !== 4'h4) begin n_fail++; $display("FAIL seq_cnt: got %h expected 4", fetch_cnt); end
   endtask

   task automatic test_redirect();
      pco = 32'h40; ihit = 1'b1; redirect_en = 1'b1; redirect_pc = 32'h100;
      #1;
      n_tests++; if (pc_nxt !== 32'h100) begin n_fail++; $display("FAIL redir_nxt: got %h expected 00000100", pc_nxt); end
      n_tests++; if (pc_wen !== 1'b1) begin n_fail++; $display("FAIL redir_wen: got %b expected 1", pc_wen); end
      n_tests++; if (fetch_valid !== 1'b0) begin n_fail++; $display("FAIL redir_fv: got %b expected 0", fetch_valid); end
      step();
      redirect_en = 1'b0;
      #1;
      n_tests++; if (pco !== 32'h100) begin n_fail++; $display("FAIL redir_pco: got %h expected 00000100", pco); end
      n_tests++; if (fetch_valid !== 1'b1) begin n_fail++; $display("FAIL redir_fv2: got %b expected 1", fetch_valid); end
   endtask

   task automatic test_deferred();
      ihit = 1'b0; redirect_en = 1'b1; redirect_pc = 32'h200;
      #1;
      n_tests++; if (pc_wen !== 1'b0) begin n_fail++; $display("FAIL defer_wen0: got %b expected 0", pc_wen); end
      step();
      redirect_en = 1'b0;
      for (int i = 0; i < 2; i++) begin
         #1;
         n_tests++; if (pc_wen !== 1'b0) begin n_fail++; $display("FAIL defer_wen[%0d]: got %b expected 0", i, pc_wen); end
         n_tests++; if (iREN !== 1'b1) begin n_fail++; $display("FAIL defer_iren[%0d]: got %b expected 1", i, iREN); end
         n_tests++; if (pc_nxt !== 32'h200) begin n_fail++; $display("FAIL defer_pend[%0d]: got %h expected 00000200", i, pc_nxt); end
         step();
      end
      ihit = 1'b1;
      #1;
      n_tests++; if (pc_nxt !== 32'h200) begin n_fail++; $display("FAIL defer_nxt: got %h expected 00000200", pc_nxt); end
      n_tests++; if (pc_wen !== 1'b1) begin n_fail++; $display("FAIL defer_wen: got %b expected 1", pc_wen); end
      n_tests++; if (fetch_valid !== 1'b0) begin n_fail++; $display("FAIL defer_fv: got %b expected 0", fetch_valid); end
      step();
      #1;
      n_tests++; if (fetch_valid !== 1'b1) begin n_fail++; $display("FAIL defer_fv2: got %b expected 1", fetch_valid); end
      n_tests++; if (pc_nxt !== 32'h204) begin n_fail++; $display("FAIL defer_clr: got %h expected 00000204", pc_nxt); end
   endtask

   task automatic test_stall_redirect();
      ihit = 1'b1; stall = 1'b1; redirect_en = 1'b1; redirect_pc = 32'h300;
      #1;
      n_tests++; if (pc_wen !== 1'b0) begin n_fail++; $display("FAIL stall_wen: got %b expected 0", pc_wen); end
      n_tests++; if (fetch_valid !== 1'b0) begin n_fail++; $display("FAIL stall_fv: got %b expected 0", fetch_valid); end
      step();
      redirect_pc = 32'h400;
      step();
      stall = 1'b0; redirect_en = 1'b0;
      #1;
      n_tests++; if (pc_nxt !== 32'h400) begin n_fail++; $display("FAIL stall_nxt: got %h expected 00000400", pc_nxt); end
      n_tests++; if (pc_wen !== 1'b1) begin n_fail++; $display("FAIL stall_wen2: got %b expected 1", pc_wen); end
      step();
      #1;
      n_tests++; if (fetch_valid !== 1'b1) begin n_fail++; $display("FAIL stall_fv2: got %b expected 1", fetch_valid); end
      n_tests++; if (pc_nxt !== 32'h404) begin n_fail++; $display("FAIL stall_clr: got %h expected 00000404", pc_nxt); end
   endtask

   task automatic test_halt();
      do_reset();
      pco = 32'h20; ihit = 1'b1; halt = 1'b1;
      #1;
      n_tests++; if (fetch_valid !== 1'b1) begin n_fail++; $display("FAIL halt_fv: got %b expected 1", fetch_valid); end
      n_tests++; if (pc_nxt !== 32'h24) begin n_fail++; $display("FAIL halt_nxt: got %h expected 00000024", pc_nxt); end
      step();
      halt = 1'b0;
      #1;
      n_tests++; if (pco !== 32'h24) begin n_fail++; $display("FAIL halt_pco: got %h expected 00000024", pco); end
      n_tests++; if (halted !== 1'b1) begin n_fail++; $display("FAIL halt_st: got %b expected 1", halted); end
      n_tests++; if (iREN !== 1'b0) begin n_fail++; $display("FAIL halt_iren: got %b expected 0", iREN); end
      n_tests++; if (pc_wen !== 1'b0) begin n_fail++; $display("FAIL halt_wen: got %b expected 0", pc_wen); end
      n_tests++; if (fetch_valid !== 1'b0) begin n_fail++; $display("FAIL halt_fv2: got %b expected 0", fetch_valid); end
      step();
      n_tests++; if (halted !== 1'b1) begin n_fail++; $display("FAIL halt_hold: got %b expected 1", halted); end
   endtask

   task automatic test_halt_squash();
      do_reset();
      pco = 32'h20; ihit = 1'b1; halt = 1'b1; redirect_en = 1'b1; redirect_pc = 32'h80;
      step();
      redirect_en = 1'b0; halt = 1'b0;
      n_tests++; if (halted !== 1'b0) begin n_fail++; $display("FAIL sq_redir: got %b expected 0", halted); end
      ihit = 1'b0; redirect_en = 1'b1; redirect_pc = 32'h90;
      step();
      ihit = 1'b1; redirect_en = 1'b0; halt = 1'b1;
      step();
      n_tests++; if (halted !== 1'b0) begin n_fail++; $display("FAIL sq_pend: got %b expected 0", halted); end
      stall = 1'b1;
      step();
      n_tests++; if (halted !== 1'b0) begin n_fail++; $display("FAIL sq_stall: got %b expected 0", halted); end
      stall = 1'b0;
      step();
      halt = 1'b0;
      n_tests++; if (halted !== 1'b1) begin n_fail++; $display("FAIL sq_release: got %b expected 1", halted); end
      n_tests++; if (fetch_cnt !== 4'h1) begin n_fail++; $display("FAIL sq_cnt: got %h expected 1", fetch_cnt); end
      nRST = 1'b0;
      #1;
      n_tests++; if (halted !== 1'b0) begin n_fail++; $display("FAIL rst_mid_halt: got %b expected 0", halted); end
      n_tests++; if (fetch_cnt !== 4'h0) begin n_fail++; $display("FAIL rst_mid_cnt: got %h expected 0", fetch_cnt); end
      n_tests++; if (iREN !== 1'b1) begin n_fail++; $display("FAIL rst_mid_iren: got %b expected 1", iREN); end
   endtask

   task automatic test_boundary();
      do_reset();
      pco = 32'hFFFF_FFFC; ihit = 1'b1;
      #1;
      n_tests++; if (pc_nxt !== 32'h0) begin n_fail++; $display("FAIL wrap_nxt: got %h expected 00000000", pc_nxt); end
      n_tests++; if (pc_wen !== 1'b1) begin n_fail++; $display("FAIL wrap_wen: got %b expected 1", pc_wen); end
      step();
      redirect_en = 1'b1; redirect_pc = 32'h103;
      #1;
      n_tests++; if (pc_nxt !== 32'h100) begin n_fail++; $display("FAIL align_nxt: got %h expected 00000100", pc_nxt); end
      step();
      redirect_en = 1'b0;
   endtask

   task automatic test_saturation();
      do_reset();
      ihit = 1'b1;
      for (int i = 0; i < 20; i++) begin
         step();
         if (i == 13) begin
            n_tests++; if (fetch_cnt !== 4'hE) begin n_fail++; $display("FAIL cnt_14: got %h expected e", fetch_cnt); end
         end
      end
      n_tests++; if (fetch_cnt !== 4'hF) begin n_fail++; $display("FAIL cnt_sat: got %h expected f", fetch_cnt); end
   endtask

   initial begin
      test_reset();
      test_sequential();
      test_redirect();
      test_deferred();
      test_stall_redirect();
      test_halt();
      test_halt_squash();
      test_boundary();
      test_saturation();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
